// File: rtl/v_issue_queue_if.sv
// Instruction + scalar-operand valid/ready bundle.
// master drives the payload, slave returns ready.
interface v_issue_queue_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic            ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;

  modport master (
    output valid, instr, rs1, rs2,
    input  ready
  );

  modport slave (
    input  valid, instr, rs1, rs2,
    output ready
  );
endinterface

// File: rtl/v_issue_queue.sv
// Vector instruction issue queue: FIFO between scalar core and
// vector decoder with in-flight limit and vset serialization.
module v_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 3,
  parameter int XLEN         = 32
) (
  input  logic clk,
  input  logic nrst,
  v_issue_queue_if.slave  in_if,
  v_issue_queue_if.master out_if,
  input  logic flush,
  output logic stall_core,
  input  logic s_done,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(MAX_INFLIGHT+1);

  typedef enum logic [1:0] {
    RUN, DRAIN, CFG_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] rs1_q   [DEPTH];
  logic [XLEN-1:0] rs2_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] inflight_q, inflight_d;

  logic full, empty, in_vec, push, pop;
  logic head_cfg, room, cfg_blk, dec;
  logic [31:0] head;
  logic [6:0]  in_op;

  assign in_op  = in_if.instr[6:0];
  assign in_vec = (in_op == 7'h57) ||
                  (in_op == 7'h07) ||
                  (in_op == 7'h27);

  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign head  = instr_q[rd_ptr_q];

  assign head_cfg = (head[6:0] == 7'h57) &&
                    (head[14:12] == 3'b111);

  assign room    = inflight_q < IW'(MAX_INFLIGHT);
  assign cfg_blk = head_cfg && (inflight_q != '0);

  assign out_if.valid = (state_q == RUN) && !empty &&
                        room && !cfg_blk;
  assign out_if.instr = head;
  assign out_if.rs1   = rs1_q[rd_ptr_q];
  assign out_if.rs2   = rs2_q[rd_ptr_q];

  assign push = in_if.valid && in_vec && !full && !flush;
  assign pop  = out_if.valid && out_if.ready && !flush;
  assign dec  = s_done && (inflight_q != '0);

  assign in_if.ready = !full;
  assign stall_core  = in_if.valid && in_vec && full;
  assign count       = count_q;
  assign inflight    = inflight_q;
  assign busy        = !empty || (inflight_q != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (pop && head_cfg)
          state_d = CFG_WAIT;
        else if (!flush && !empty && cfg_blk)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (flush || inflight_q == '0)
          state_d = RUN;
      end
      CFG_WAIT: begin
        if (s_done)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    unique case (1'b1)
      flush: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      default: begin
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
      end
    endcase
    // pop and a completion in one cycle cancel out
    inflight_d = inflight_q + IW'(pop) - IW'(dec);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        rs1_q[i]   <= '0;
        rs2_q[i]   <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= in_if.instr;
      rs1_q[wr_ptr_q]   <= in_if.rs1;
      rs2_q[wr_ptr_q]   <= in_if.rs2;
    end
  end
endmodule

// File: tb/tb_v_issue_queue.sv
// Directed bench for v_issue_queue with an in-order
// scoreboard of expected {instr, rs1, rs2} issues.
module tb_v_issue_queue;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic flush = 1'b0;
  logic s_done = 1'b0;
  logic stall_core, busy;
  logic [2:0] count;
  logic [1:0] inflight;

  int checks = 0;
  int errors = 0;
  logic [95:0] sb[$];

  localparam logic [31:0] VADD = 32'h0220_8057;
  localparam logic [31:0] VSET = 32'h0101_70D7;
  localparam logic [31:0] ADDI = 32'h0010_0093;

  v_issue_queue_if #(.XLEN(32)) in_b ();
  v_issue_queue_if #(.XLEN(32)) out_b ();

  v_issue_queue #(
    .DEPTH(4), .MAX_INFLIGHT(3), .XLEN(32)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .in_if(in_b.slave),
    .out_if(out_b.master),
    .flush(flush),
    .stall_core(stall_core),
    .s_done(s_done),
    .count(count),
    .inflight(inflight),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] w,
                     input logic [31:0] a,
                     input logic [31:0] b);
    in_b.valid = 1'b1;
    in_b.instr = w;
    in_b.rs1   = a;
    in_b.rs2   = b;
  endtask

  task automatic idle();
    in_b.valid = 1'b0;
    in_b.instr = '0;
    in_b.rs1   = '0;
    in_b.rs2   = '0;
  endtask

  task automatic expq(input logic [31:0] w,
                      input logic [31:0] a,
                      input logic [31:0] b);
    sb.push_back({w, a, b});
  endtask

  task automatic settle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (count == 0 && inflight == 0) break;
      tick();
    end
    chk("settle_count", 96'(count), 96'(0));
    chk("settle_inflight", 96'(inflight), 96'(0));
  endtask

  always @(negedge clk) begin
    if (nrst && out_b.valid && out_b.ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pop: observed %0h expected none",
               out_b.instr);
      end else begin
        chk("pop_order",
            {out_b.instr, out_b.rs1, out_b.rs2},
            sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] w;
    idle();
    out_b.ready = 1'b0;
    #1;
    chk("rst_out_valid", 96'(out_b.valid), 96'(0));
    chk("rst_in_ready", 96'(in_b.ready), 96'(1));
    chk("rst_stall", 96'(stall_core), 96'(0));
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_out_instr", 96'(out_b.instr), 96'(0));
    chk("rst_count", 96'(count), 96'(0));
    chk("rst_inflight", 96'(inflight), 96'(0));
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // basic issue
    out_b.ready = 1'b1;
    drv(VADD, 32'h11, 32'h22);
    expq(VADD, 32'h11, 32'h22);
    tick();
    idle();
    chk("basic_valid", 96'(out_b.valid), 96'(1));
    chk("basic_inflight0", 96'(inflight), 96'(0));
    tick();
    chk("basic_inflight1", 96'(inflight), 96'(1));
    chk("basic_empty", 96'(out_b.valid), 96'(0));
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    chk("basic_done", 96'(inflight), 96'(0));
    chk("basic_busy", 96'(busy), 96'(0));

    // non-vector filter
    drv(ADDI, 32'h1, 32'h2);
    #1;
    chk("nv_stall", 96'(stall_core), 96'(0));
    tick();
    idle();
    chk("nv_count", 96'(count), 96'(0));
    chk("nv_valid", 96'(out_b.valid), 96'(0));

    // full and wrap-around
    out_b.ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = VADD + (32'(k) << 7);
      drv(w, 32'(k), 32'(k + 100));
      #1;
      if (k < 4) begin
        chk("full_ready", 96'(in_b.ready), 96'(1));
        expq(w, 32'(k), 32'(k + 100));
      end else begin
        chk("full_noready", 96'(in_b.ready), 96'(0));
        chk("full_stall", 96'(stall_core), 96'(1));
      end
      tick();
    end
    idle();
    chk("full_count", 96'(count), 96'(4));
    out_b.ready = 1'b1;
    s_done = 1'b1;
    tick();
    for (int k = 5; k < 9; k++) begin
      w = VADD + (32'(k) << 7);
      drv(w, 32'(k), 32'(k + 100));
      #1;
      chk("wrap_ready", 96'(in_b.ready), 96'(1));
      expq(w, 32'(k), 32'(k + 100));
      tick();
    end
    idle();
    settle(20);
    s_done = 1'b0;

    // in-flight limit
    for (int k = 0; k < 5; k++) begin
      w = VADD + (32'(k + 16) << 7);
      drv(w, 32'(k + 200), 32'(k + 300));
      expq(w, 32'(k + 200), 32'(k + 300));
      tick();
    end
    idle();
    chk("lim_valid", 96'(out_b.valid), 96'(0));
    chk("lim_inflight", 96'(inflight), 96'(3));
    chk("lim_count", 96'(count), 96'(2));
    s_done = 1'b1;
    tick();
    chk("lim_dec", 96'(inflight), 96'(2));
    chk("lim_reopen", 96'(out_b.valid), 96'(1));
    tick();
    chk("lim_same", 96'(inflight), 96'(2));
    chk("lim_count1", 96'(count), 96'(1));
    settle(20);
    s_done = 1'b0;

    // vsetvli serialization
    drv(VADD, 32'h31, 32'h32);
    expq(VADD, 32'h31, 32'h32);
    tick();
    drv(VSET, 32'h41, 32'h42);
    expq(VSET, 32'h41, 32'h42);
    chk("cfg_first", 96'(out_b.valid), 96'(1));
    tick();
    w = VADD + 32'h80;
    drv(w, 32'h51, 32'h52);
    expq(w, 32'h51, 32'h52);
    chk("cfg_block", 96'(out_b.valid), 96'(0));
    tick();
    idle();
    s_done = 1'b1;
    chk("cfg_drain", 96'(out_b.valid), 96'(0));
    tick();
    s_done = 1'b0;
    chk("cfg_drain2", 96'(out_b.valid), 96'(0));
    tick();
    chk("cfg_issue", 96'(out_b.valid), 96'(1));
    tick();
    chk("cfg_wait", 96'(out_b.valid), 96'(0));
    chk("cfg_wait_inf", 96'(inflight), 96'(1));
    tick();
    chk("cfg_wait2", 96'(out_b.valid), 96'(0));
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    chk("cfg_resume", 96'(out_b.valid), 96'(1));
    tick();
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    settle(10);

    // flush in CFG_WAIT
    out_b.ready = 1'b0;
    drv(VSET, 32'h61, 32'h62);
    expq(VSET, 32'h61, 32'h62);
    tick();
    for (int k = 0; k < 3; k++) begin
      w = VADD + (32'(k + 24) << 7);
      drv(w, 32'(k), 32'(k));
      expq(w, 32'(k), 32'(k));
      tick();
    end
    idle();
    out_b.ready = 1'b1;
    tick();
    chk("fl_pre_count", 96'(count), 96'(3));
    chk("fl_pre_inf", 96'(inflight), 96'(1));
    sb.delete();
    flush = 1'b1;
    drv(VADD, 32'h71, 32'h72);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_count", 96'(count), 96'(0));
    chk("fl_inflight", 96'(inflight), 96'(1));
    chk("fl_valid", 96'(out_b.valid), 96'(0));
    w = VADD + 32'h100;
    drv(w, 32'h81, 32'h82);
    expq(w, 32'h81, 32'h82);
    tick();
    idle();
    chk("fl_cfgwait", 96'(out_b.valid), 96'(0));
    chk("fl_count1", 96'(count), 96'(1));
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    chk("fl_resume", 96'(out_b.valid), 96'(1));
    tick();
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    settle(10);

    // reset in mid-operation
    out_b.ready = 1'b0;
    drv(VADD, 32'h91, 32'h92);
    tick();
    tick();
    idle();
    nrst = 1'b0;
    #1;
    chk("mrst_count", 96'(count), 96'(0));
    chk("mrst_valid", 96'(out_b.valid), 96'(0));
    chk("mrst_ready", 96'(in_b.ready), 96'(1));
    tick();
    nrst = 1'b1;
    tick();

    chk("sb_empty", 96'(sb.size()), 96'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
